// File: rtl/itch_pkg.sv
// Shared types and defaults for the ITCH message assembler.
package itch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam int DEF_BEAT_BYTES    = 8;
  localparam int DEF_MAX_MSG_BYTES = 64;

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/itch_byte_aligner.sv
// Shifts the useful bytes of one input beat down to byte 0, then up to the
// capture-buffer write index, and produces a per-byte write mask limited to
// the bytes taken from this beat and to the (clamped) capture length.
module itch_byte_aligner
  import itch_pkg::*;
#(
  parameter  int BEAT_BYTES    = DEF_BEAT_BYTES,
  parameter  int MAX_MSG_BYTES = DEF_MAX_MSG_BYTES,
  localparam int OFS_W         = $clog2(BEAT_BYTES),
  localparam int LEN_W         = $clog2(MAX_MSG_BYTES + 1)
) (
  input  logic [8*BEAT_BYTES-1:0]    beat,
  input  logic [OFS_W-1:0]           rd_ofs,
  input  logic [LEN_W-1:0]           wr_idx,
  input  logic [OFS_W:0]             take,
  input  logic [LEN_W-1:0]           cap_len,
  output logic [8*MAX_MSG_BYTES-1:0] wr_data,
  output logic [MAX_MSG_BYTES-1:0]   wr_mask
);

  logic [8*BEAT_BYTES-1:0]    aligned;
  logic [8*MAX_MSG_BYTES-1:0] widened;
  logic [MAX_MSG_BYTES-1:0]   all_ones;
  logic [MAX_MSG_BYTES-1:0]   take_mask;
  logic [MAX_MSG_BYTES-1:0]   cap_mask;

  // Byte placement is pure shifting; shifting past the vector width yields zero,
  // which also handles write indices beyond the clamped buffer.
  always_comb begin
    all_ones  = '1;
    aligned   = beat >> {rd_ofs, 3'b000};
    widened   = (8*MAX_MSG_BYTES)'(aligned);
    take_mask = ~(all_ones << take);
    cap_mask  = ~(all_ones << cap_len);
    wr_data   = widened << {wr_idx, 3'b000};
    wr_mask   = (take_mask << wr_idx) & cap_mask;
  end

endmodule

// File: rtl/itch_msg_assembler.sv
// Assembles one ITCH message from a byte-aligned beat stream into a flat
// buffer, holding it until the consumer accepts it.
// Optional feature: define ITCH_LEN_CHECK_EN to add len_err and drop messages
// longer than MAX_MSG_BYTES instead of silently clamping them.
module itch_msg_assembler
  import itch_pkg::*;
#(
  parameter  int BEAT_BYTES    = DEF_BEAT_BYTES,
  parameter  int MAX_MSG_BYTES = DEF_MAX_MSG_BYTES,
  localparam int OFS_W         = $clog2(BEAT_BYTES),
  localparam int LEN_W         = $clog2(MAX_MSG_BYTES + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [8*BEAT_BYTES-1:0]    in_data,
  input  logic                       start,
  input  logic [OFS_W-1:0]           start_offset,
  input  logic [LEN_W-1:0]           msg_len,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [8*MAX_MSG_BYTES-1:0] out_msg,
  output logic [LEN_W-1:0]           out_len,
  output logic [OFS_W-1:0]           tracker_out,
  output logic                       partial_out,
`ifdef ITCH_LEN_CHECK_EN
  output logic                       len_err,
`endif
  output logic                       busy
);

`ifdef ITCH_LEN_CHECK_EN
  localparam bit LEN_CHECK = 1'b1;
`else
  localparam bit LEN_CHECK = 1'b0;
`endif

  state_t                     state, state_next;
  logic [LEN_W:0]             remaining;     // one extra bit so subtraction cannot wrap
  logic [LEN_W-1:0]           wr_idx;
  logic [LEN_W-1:0]           cap_len;
  logic [OFS_W-1:0]           track_pend;
  logic                       drop;
  logic [8*MAX_MSG_BYTES-1:0] cap_buf;

  // Per-cycle view of the current beat, valid in IDLE (from start fields) and COLLECT.
  logic                       accept;
  logic                       capture;
  logic                       enter_hold;
  logic [OFS_W-1:0]           rd_ofs;
  logic [LEN_W-1:0]           wr_base;
  logic [OFS_W:0]             take_v;
  logic [LEN_W-1:0]           cap_use;
  logic [OFS_W-1:0]           trk_use;
  logic                       drop_use;
  logic [LEN_W:0]             rem_next;
  logic [LEN_W-1:0]           wr_next;
  logic [8*MAX_MSG_BYTES-1:0] wr_data;
  logic [MAX_MSG_BYTES-1:0]   wr_mask;
  logic [8*MAX_MSG_BYTES-1:0] buf_next;
  int                         take_i;
  int                         rem_i;

  itch_byte_aligner #(
    .BEAT_BYTES   (BEAT_BYTES),
    .MAX_MSG_BYTES(MAX_MSG_BYTES)
  ) u_aligner (
    .beat   (in_data),
    .rd_ofs (rd_ofs),
    .wr_idx (wr_base),
    .take   (take_v),
    .cap_len(cap_use),
    .wr_data(wr_data),
    .wr_mask(wr_mask)
  );

  // Next-state, handshake and per-beat byte accounting.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves one unassigned (no latch).
    state_next = state;
    in_ready   = 1'b0;
    rd_ofs     = '0;
    wr_base    = wr_idx;
    cap_use    = cap_len;
    trk_use    = track_pend;
    drop_use   = drop;
    take_i     = 0;
    rem_i      = 0;
    unique case (state)
      IDLE: begin
        in_ready = start && !rst;
        rd_ofs   = start_offset;
        wr_base  = '0;
        cap_use  = LEN_W'(min_int(int'(msg_len), MAX_MSG_BYTES));
        trk_use  = OFS_W'(int'(start_offset) + int'(msg_len));
        drop_use = LEN_CHECK && (int'(msg_len) > MAX_MSG_BYTES);
        take_i   = min_int(BEAT_BYTES - int'(start_offset), int'(msg_len));
        rem_i    = int'(msg_len) - take_i;
      end
      COLLECT: begin
        in_ready = !rst;
        take_i   = min_int(BEAT_BYTES, int'(remaining));
        rem_i    = int'(remaining) - take_i;
      end
      HOLD: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    accept  = in_valid && in_ready;
    capture = accept && ((state != IDLE) || (msg_len != '0));
    if (capture) begin
      if (rem_i == 0) state_next = drop_use ? IDLE : HOLD;
      else            state_next = COLLECT;
    end
    enter_hold = (state != HOLD) && (state_next == HOLD);

    take_v   = (OFS_W+1)'(take_i);
    rem_next = (LEN_W+1)'(rem_i);
    wr_next  = LEN_W'(int'(wr_base) + take_i);
  end

  // Merge the aligned beat into the buffer; a start beat clears stale bytes.
  always_comb begin
    buf_next = '0;
    for (int k = 0; k < MAX_MSG_BYTES; k++) begin
      if (wr_mask[k])         buf_next[8*k +: 8] = wr_data[8*k +: 8];
      else if (state != IDLE) buf_next[8*k +: 8] = cap_buf[8*k +: 8];
    end
  end

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the capture buffer is reset too, because out_msg must read zero after reset.
      state       <= IDLE;
      remaining   <= '0;
      wr_idx      <= '0;
      cap_len     <= '0;
      track_pend  <= '0;
      drop        <= 1'b0;
      cap_buf     <= '0;
      out_len     <= '0;
      tracker_out <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_next;
      if (capture) begin
        remaining <= rem_next;
        wr_idx    <= wr_next;
        cap_buf   <= buf_next;
        if (state == IDLE) begin
          cap_len    <= cap_use;
          track_pend <= trk_use;
          drop       <= drop_use;
        end
      end
      if (enter_hold) begin
        out_len     <= cap_use;
        tracker_out <= trk_use;
      end
    end
  end

`ifdef ITCH_LEN_CHECK_EN
  // One-cycle flag for an oversized message accepted at start.
  always_ff @(posedge clk) begin
    if (rst) len_err <= 1'b0;
    else     len_err <= capture && (state == IDLE) && drop_use;
  end
`endif

  assign out_valid   = (state == HOLD);
  assign busy        = (state != IDLE);
  assign out_msg     = cap_buf;
  assign partial_out = (tracker_out != '0);

endmodule

// File: tb/tb_itch_msg_assembler.sv
// Scoreboard bench for itch_msg_assembler (default BEAT_BYTES=8, MAX_MSG_BYTES=64).
module tb_itch_msg_assembler;

  localparam int BB    = 8;
  localparam int MAXB  = 64;
  localparam int OFS_W = 3;
  localparam int LEN_W = 7;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [8*BB-1:0]   in_data = '0;
  logic              start = 1'b0;
  logic [OFS_W-1:0]  start_offset = '0;
  logic [LEN_W-1:0]  msg_len = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [8*MAXB-1:0] out_msg;
  logic [LEN_W-1:0]  out_len;
  logic [OFS_W-1:0]  tracker_out;
  logic              partial_out;
  logic              busy;
`ifdef ITCH_LEN_CHECK_EN
  logic              len_err;
`endif

  typedef struct {
    logic [8*MAXB-1:0] msg;
    logic [LEN_W-1:0]  len;
    logic [OFS_W-1:0]  trk;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  itch_msg_assembler dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .start       (start),
    .start_offset(start_offset),
    .msg_len     (msg_len),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_msg     (out_msg),
    .out_len     (out_len),
    .tracker_out (tracker_out),
    .partial_out (partial_out),
`ifdef ITCH_LEN_CHECK_EN
    .len_err     (len_err),
`endif
    .busy        (busy)
  );

  task automatic check(input string name, input logic [8*MAXB-1:0] act, input logic [8*MAXB-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on each output handshake; checks HOLD stability.
  logic              prev_v = 1'b0;
  logic [8*MAXB-1:0] prev_msg = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid && prev_v) check("hold_stable", out_msg, prev_msg);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out actual=out_valid required=no_message");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_msg", out_msg, e.msg);
          check("out_len", out_len, e.len);
          check("tracker_out", tracker_out, e.trk);
          check("partial_out", partial_out, e.trk != '0);
        end
        prev_v = 1'b0;
      end else begin
        prev_v   = out_valid;
        prev_msg = out_msg;
      end
    end
  end

  // Presents one beat and waits (bounded) for acceptance; returns at posedge+1.
  task automatic put_beat(input logic [8*BB-1:0] d, input logic st,
                          input logic [OFS_W-1:0] ofs, input logic [LEN_W-1:0] len);
    logic ok = 1'b0;
    int   n  = 0;
    in_data = d; in_valid = 1'b1; start = st; start_offset = ofs; msg_len = len;
    while (!ok && n < 100) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b0; start = 1'b0;
    check("beat_accepted", ok, 1'b1);
  endtask

  // Sends a whole message: filler 0xEE before the offset, message bytes base+k,
  // then 0xAA for bytes belonging to the next message.
  task automatic send_msg(input int ofs, input int len, input logic [7:0] base, input bit gaps);
    exp_t            e;
    logic [8*BB-1:0] d;
    int              pos = 0;
    bit              drop = 1'b0;
`ifdef ITCH_LEN_CHECK_EN
    drop = (len > MAXB);
`endif
    e.msg = '0;
    for (int k = 0; k < len && k < MAXB; k++) e.msg[8*k +: 8] = 8'(int'(base) + k);
    e.len = LEN_W'((len < MAXB) ? len : MAXB);
    e.trk = OFS_W'(ofs + len);
    if (len != 0 && !drop) exp_q.push_back(e);

    for (int i = 0; i < BB; i++)
      if (i < ofs)        d[8*i +: 8] = 8'hEE;
      else if (pos < len) begin d[8*i +: 8] = 8'(int'(base) + pos); pos++; end
      else                d[8*i +: 8] = 8'hAA;
    put_beat(d, 1'b1, OFS_W'(ofs), LEN_W'(len));
`ifdef ITCH_LEN_CHECK_EN
    check("len_err", len_err, len > MAXB);
`endif
    while (pos < len) begin
      if (gaps) begin
        in_data = {BB{8'h5A}};
        @(posedge clk); #1;
        check("stall_busy", busy, 1'b1);
      end
      for (int i = 0; i < BB; i++)
        if (pos < len) begin d[8*i +: 8] = 8'(int'(base) + pos); pos++; end
        else           d[8*i +: 8] = 8'hAA;
      put_beat(d, 1'b0, '0, '0);
    end
    check("out_valid_latency", out_valid, (len != 0) && !drop);
  endtask

  initial begin
    logic [8*BB-1:0] d;

    // Reset: in_ready must stay low even with start asserted.
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("in_ready_in_rst", in_ready, 1'b0);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_out_msg", out_msg, '0);
    check("rst_out_len", out_len, '0);
    check("rst_tracker", tracker_out, '0);
    check("rst_partial", partial_out, 1'b0);

    // Single aligned 8-byte beat: 0x0706050403020100.
    send_msg(0, 8, 8'h00, 1'b0);
    // Offset 5, length 36: spans six beats, tracker 1.
    send_msg(5, 36, 8'h10, 1'b0);
    // Fits in the start beat: IDLE->HOLD directly, tracker 5.
    send_msg(2, 3, 8'h80, 1'b0);
    // Zero length: beat consumed, nothing produced.
    send_msg(4, 0, 8'h00, 1'b0);
    check("zero_len_busy", busy, 1'b0);

    // Stalls in COLLECT plus a consumer that waits 10 cycles.
    out_ready = 1'b0;
    send_msg(3, 20, 8'h30, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check("hold_out_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("hold_released", out_valid, 1'b0);

    // Reset arriving on the third beat of a 40-byte message.
    d = {8{8'h11}};
    put_beat(d, 1'b1, '0, LEN_W'(40));
    put_beat(d, 1'b0, '0, '0);
    in_data = d; in_valid = 1'b1; start = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    check("abort_in_ready", in_ready, 1'b0);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_out_msg", out_msg, '0);
    check("abort_out_len", out_len, '0);
    check("abort_tracker", tracker_out, '0);
    rst = 1'b0; in_valid = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    send_msg(0, 8, 8'hA0, 1'b0);

    // Oversized message: clamped to 64 bytes (or dropped with len_err).
    send_msg(0, 70, 8'h40, 1'b0);
    @(posedge clk); #1;
    check("oversize_idle", busy, 1'b0);
    // Full-size message at the last start offset, tracker 7.
    send_msg(7, 64, 8'hC0, 1'b0);

    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
